// File: rtl/vr_rr_arbiter.sv
// vr_rr_arbiter: round-robin N-source valid/ready arbiter feeding a
// one-entry registered output stage. A new winner can be loaded in the
// same cycle the sink takes the held entry, so the throughput is one
// transfer per cycle.
module vr_rr_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_SRC-1:0]           in_valid,
  input  logic [N_SRC*DATA_W-1:0]    in_data,
  output logic [N_SRC-1:0]           in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(N_SRC)-1:0]   out_src,
  output logic [15:0]                xfer_cnt
);

  localparam int SRC_W = $clog2(N_SRC);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [SRC_W-1:0] lastGrant;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] cand;
  logic             found;
  logic             anyValid;
  logic             loadEn;
  logic             accept;

  // The search for the winner starts just after the last winner and wraps, so each source gets a fair turn.
  always_comb begin
    grant = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = SRC_W'((int'(lastGrant) + k) % N_SRC);
      if (!found && in_valid[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  // The output register can take new data when it is empty or is being drained in this cycle.
  always_comb begin
    anyValid = |in_valid;
    loadEn   = (state == EMPTY) || out_ready;
    accept   = loadEn && anyValid && !reset;
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Next-state logic: loading keeps the stage full, and draining with no new load empties it.
  always_comb begin
    stateNext = state;
    if (accept) begin
      stateNext = FULL;
    end else if ((state == FULL) && out_ready) begin
      stateNext = EMPTY;
    end
  end

  // State register. An asynchronous reset drops any entry that is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  assign out_valid = (state == FULL);

  // Payload, source tag and grant pointer are captured on acceptance. The counter advances on each sink handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_src   <= '0;
      lastGrant <= SRC_W'(N_SRC - 1);
      xfer_cnt  <= '0;
    end else begin
      if (accept) begin
        out_data  <= in_data[grant*DATA_W +: DATA_W];
        out_src   <= grant;
        lastGrant <= grant;
      end
      if ((state == FULL) && out_ready) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
    end
  end

endmodule
